fetch_stage: RTL and testbench

Instruction fetch stage of the 54-instruction MIPS pipeline. Owns the PC, issues word reads to instruction memory and holds the IF/ID pipeline register that feeds the ID-stage field decoder. Supports ID back-pressure through a one-entry skid buffer and PC redirect from branch/jump resolution. A redirect always squashes the younger fetched words.

---
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory read port, IF/ID register and one-entry skid buffer.
// Optional macro FETCH_MISALIGN_EXC_EN: a misaligned redirect delivers an exception entry and halts fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_exc
);

  // Handshakes: imem_addr is held until imem_ready; IF/ID is consumed when
  // id_valid && !stall_id; an empty IF/ID (id_valid=0) always accepts.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] skid_instr;
  logic [31:0] skid_instr_next;
  logic [31:0] skid_pc;
  logic [31:0] skid_pc_next;

  logic        id_valid_next;
  logic [31:0] id_instruction_next;
  logic [31:0] id_pc_next;
  logic [31:0] id_pc_plus4_next;
  logic        id_exc_q;
  logic        id_exc_next;

  logic        id_accepts;
  logic        redirect_misaligned;

`ifdef FETCH_MISALIGN_EXC_EN
  assign redirect_misaligned = |redirect_pc[1:0];
  assign id_exc              = id_exc_q;
`else
  assign redirect_misaligned = 1'b0;
  assign id_exc              = 1'b0;
`endif

  assign id_accepts = !id_valid || !stall_id;
  assign pc_plus4   = pc + 32'd4;
  assign imem_addr  = pc;
  assign imem_req   = !rst && (state == S_FETCH);

  always_comb begin
    state_next          = state;
    pc_next             = pc;
    skid_instr_next     = skid_instr;
    skid_pc_next        = skid_pc;
    id_valid_next       = id_valid;
    id_instruction_next = id_instruction;
    id_pc_next          = id_pc;
    id_pc_plus4_next    = id_pc_plus4;
    id_exc_next         = id_exc_q;

    if (redirect_valid) begin
      // Flush wins over stall, memory response and current state.
      pc_next       = {redirect_pc[31:2], 2'b00};
      id_valid_next = 1'b0;
      state_next    = S_FETCH;
      if (redirect_misaligned) begin
        id_valid_next       = 1'b1;
        id_exc_next         = 1'b1;
        id_instruction_next = 32'h0;
        id_pc_next          = redirect_pc;
        id_pc_plus4_next    = redirect_pc + 32'd4;
        state_next          = S_HALT;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            pc_next = pc_plus4;
            if (id_accepts) begin
              id_valid_next       = 1'b1;
              id_instruction_next = imem_rdata;
              id_pc_next          = pc;
              id_pc_plus4_next    = pc_plus4;
              id_exc_next         = 1'b0;
            end else begin
              skid_instr_next = imem_rdata;
              skid_pc_next    = pc;
              state_next      = S_WAIT;
            end
          end else if (id_accepts) begin
            id_valid_next = 1'b0;
          end
        end
        S_WAIT: begin
          // No request this cycle: the skid word moves into IF/ID first.
          if (!stall_id) begin
            id_valid_next       = 1'b1;
            id_instruction_next = skid_instr;
            id_pc_next          = skid_pc;
            id_pc_plus4_next    = skid_pc + 32'd4;
            id_exc_next         = 1'b0;
            state_next          = S_FETCH;
          end
        end
        S_HALT: begin
          if (id_accepts) begin
            id_valid_next = 1'b0;
          end
        end
        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_FETCH;
      pc             <= RESET_PC;
      skid_instr     <= 32'h0;
      skid_pc        <= 32'h0;
      id_valid       <= 1'b0;
      id_instruction <= 32'h0;
      id_pc          <= 32'h0;
      id_pc_plus4    <= 32'h0;
      id_exc_q       <= 1'b0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      skid_instr     <= skid_instr_next;
      skid_pc        <= skid_pc_next;
      id_valid       <= id_valid_next;
      id_instruction <= id_instruction_next;
      id_pc          <= id_pc_next;
      id_pc_plus4    <= id_pc_plus4_next;
      id_exc_q       <= id_exc_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle checks plus an in-order scoreboard of words consumed by ID.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_exc;

  int n_vec = 0;
  int n_err = 0;

  // {instruction, pc, pc_plus4, exc}
  logic [96:0] exp_q[$];

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_exc         (id_exc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] pc);
    exp_q.push_back({pc ^ 32'hA5A5_0000, pc, pc + 32'd4, 1'b0});
  endtask

  task automatic cyc(input logic ready, input logic stall, input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    imem_ready     = ready;
    stall_id       = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  // Monitor: every word ID takes must be the next expected one.
  always @(negedge clk) begin
    if (!rst && id_valid && !stall_id && !redirect_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL id_word @%0t: got unexpected pc=%h, expected none", $time, id_pc);
      end else begin
        logic [96:0] e;
        e = exp_q.pop_front();
        if ({id_instruction, id_pc, id_pc_plus4, id_exc} !== e) begin
          n_err++;
          $display("FAIL id_word @%0t: got instr=%h pc=%h pc4=%h exc=%b, expected instr=%h pc=%h pc4=%h exc=%b",
                   $time, id_instruction, id_pc, id_pc_plus4, id_exc, e[96:65], e[64:33], e[32:1], e[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    rst            = 1'b1;
    imem_ready     = 1'b0;
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_instr", id_instruction, 32'h0);
    check("rst_pc", id_pc, 32'h0);
    check("rst_pc4", id_pc_plus4, 32'h0);
    check("rst_exc", {31'h0, id_exc}, 32'h0);

    // Streaming from reset PC
    for (int k = 0; k < 8; k++) begin
      push_word(32'h0040_0000 + 32'(4 * k));
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      check("stream_addr", imem_addr, 32'h0040_0000 + 32'(4 * k));
      check("stream_req", {31'h0, imem_req}, 32'h1);
      if (k > 0) begin
        check("stream_valid", {31'h0, id_valid}, 32'h1);
        check("stream_idpc", id_pc, 32'h0040_0000 + 32'(4 * (k - 1)));
        check("stream_pc4", id_pc_plus4, 32'h0040_0000 + 32'(4 * k));
      end else begin
        check("first_valid", {31'h0, id_valid}, 32'h0);
      end
    end

    // Three-cycle stall: one word into skid, no request while waiting
    push_word(32'h0040_0020);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("stall_req0", {31'h0, imem_req}, 32'h1);
    check("stall_idpc0", id_pc, 32'h0040_001C);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("wait_req1", {31'h0, imem_req}, 32'h0);
    check("wait_idpc1", id_pc, 32'h0040_001C);
    check("wait_valid1", {31'h0, id_valid}, 32'h1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("wait_req2", {31'h0, imem_req}, 32'h0);
    check("wait_addr2", imem_addr, 32'h0040_0024);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("unstall_req", {31'h0, imem_req}, 32'h0);
    check("unstall_idpc", id_pc, 32'h0040_001C);
    push_word(32'h0040_0024);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("skid_idpc", id_pc, 32'h0040_0020);
    check("resume_addr", imem_addr, 32'h0040_0024);
    check("resume_req", {31'h0, imem_req}, 32'h1);
    push_word(32'h0040_0028);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("resume_idpc", id_pc, 32'h0040_0024);

    // Memory wait states
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("ws_addr0", imem_addr, 32'h0040_002C);
    check("ws_valid0", {31'h0, id_valid}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("ws_addr1", imem_addr, 32'h0040_002C);
    check("ws_valid1", {31'h0, id_valid}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("ws_addr2", imem_addr, 32'h0040_002C);
    check("ws_valid2", {31'h0, id_valid}, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("ws_deliver_valid", {31'h0, id_valid}, 32'h1);
    check("ws_deliver_pc", id_pc, 32'h0040_002C);
    check("ws_deliver_instr", id_instruction, 32'hA5E5_002C);

    // Redirect with skid full, stall asserted and IF/ID live
    cyc(1'b1, 1'b1, 1'b1, 32'h0040_0100);
    check("redir_wait_req", {31'h0, imem_req}, 32'h0);
    check("redir_wait_valid", {31'h0, id_valid}, 32'h1);
    push_word(32'h0040_0100);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_flush_valid", {31'h0, id_valid}, 32'h0);
    check("redir_addr", imem_addr, 32'h0040_0100);
    check("redir_req", {31'h0, imem_req}, 32'h1);
    push_word(32'h0040_0104);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_idpc0", id_pc, 32'h0040_0100);
    check("redir_addr1", imem_addr, 32'h0040_0104);
    push_word(32'h0040_0108);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_idpc1", id_pc, 32'h0040_0104);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_idpc2", id_pc, 32'h0040_0108);

    // Redirect in FETCH together with stall: flush wins
    cyc(1'b1, 1'b1, 1'b1, 32'h0040_0180);
    check("rs_valid_before", {31'h0, id_valid}, 32'h1);
    check("rs_idpc_before", id_pc, 32'h0040_010C);
    push_word(32'h0040_0180);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("rs_flush_valid", {31'h0, id_valid}, 32'h0);
    check("rs_addr", imem_addr, 32'h0040_0180);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("rs_idpc", id_pc, 32'h0040_0180);

    // Misaligned redirect target
    cyc(1'b1, 1'b0, 1'b1, 32'h0040_0102);
    check("mis_prev_idpc", id_pc, 32'h0040_0184);
`ifdef FETCH_MISALIGN_EXC_EN
    exp_q.push_back({32'h0, 32'h0040_0102, 32'h0040_0106, 1'b1});
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("exc_valid", {31'h0, id_valid}, 32'h1);
    check("exc_flag", {31'h0, id_exc}, 32'h1);
    check("exc_instr", id_instruction, 32'h0);
    check("exc_idpc", id_pc, 32'h0040_0102);
    check("exc_pc4", id_pc_plus4, 32'h0040_0106);
    check("exc_req0", {31'h0, imem_req}, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("exc_hold_valid", {31'h0, id_valid}, 32'h1);
    check("exc_req1", {31'h0, imem_req}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("exc_req2", {31'h0, imem_req}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("halt_valid", {31'h0, id_valid}, 32'h0);
    check("halt_req", {31'h0, imem_req}, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 32'h0040_0200);
    check("halt_req_redir", {31'h0, imem_req}, 32'h0);
`else
    push_word(32'h0040_0100);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("mask_addr", imem_addr, 32'h0040_0100);
    check("mask_valid", {31'h0, id_valid}, 32'h0);
    check("mask_req", {31'h0, imem_req}, 32'h1);
    check("mask_exc", {31'h0, id_exc}, 32'h0);
    push_word(32'h0040_0104);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("mask_idpc", id_pc, 32'h0040_0100);
    check("mask_exc1", {31'h0, id_exc}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("mask_wait_req", {31'h0, imem_req}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("mask_idpc1", id_pc, 32'h0040_0104);
    check("mask_addr1", imem_addr, 32'h0040_0108);
    cyc(1'b1, 1'b0, 1'b1, 32'h0040_0200);
`endif
    push_word(32'h0040_0200);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("r200_addr", imem_addr, 32'h0040_0200);
    check("r200_req", {31'h0, imem_req}, 32'h1);
    check("r200_valid", {31'h0, id_valid}, 32'h0);
    push_word(32'h0040_0204);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("r200_idpc", id_pc, 32'h0040_0200);
    check("r200_exc", {31'h0, id_exc}, 32'h0);
    push_word(32'h0040_0208);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    push_word(32'h0040_020C);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("r200_last", id_pc, 32'h0040_020C);

    // PC wrap at the top of the address space
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    push_word(32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_valid0", {31'h0, id_valid}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);
    check("wrap_idpc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc_plus4, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_bubble", {31'h0, id_valid}, 32'h0);

    check("drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
